// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the alarm clock's alarm controller:
// state encoding, time limits and field widths.
package alarm_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int TMR_W  = 4;

  localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZED = 2'd3
  } alarm_state_e;

endpackage

// File: rtl/alarm_controller_if.sv
// Signal bundle between the clock/user-input side and the alarm controller.
interface alarm_controller_if;
  import alarm_pkg::*;

  // All strobes (MinTick, AlarmSet, Snooze, Stop) are single-cycle requests
  // sampled on every rising Clk edge; there is no back-pressure, so a strobe
  // held high for N cycles is taken as N separate requests.
  logic [HOUR_W-1:0] Hour;
  logic [MIN_W-1:0]  Minute;
  logic              MinTick;
  logic              Arm;
  logic              AlarmSet;
  logic [HOUR_W-1:0] SetHour;
  logic [MIN_W-1:0]  SetMin;
  logic              Snooze;
  logic              Stop;
  logic              Buzzer;
  logic [HOUR_W-1:0] AlarmHour;
  logic [MIN_W-1:0]  AlarmMin;
  logic [1:0]        State;
  logic [2:0]        SnoozeCnt;

  modport master (
    output Hour, Minute, MinTick, Arm, AlarmSet, SetHour, SetMin, Snooze, Stop,
    input  Buzzer, AlarmHour, AlarmMin, State, SnoozeCnt
  );

  modport slave (
    input  Hour, Minute, MinTick, Arm, AlarmSet, SetHour, SetMin, Snooze, Stop,
    output Buzzer, AlarmHour, AlarmMin, State, SnoozeCnt
  );

endinterface

// File: rtl/alarm_controller_min_timer.sv
// Loadable minute down-counter shared by ring and snooze timing; expire
// pulses on the tick that moves the count from 1 to 0.
module min_timer
  import alarm_pkg::*;
(
  input  logic             Clk,
  input  logic             Clr,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [TMR_W-1:0] count_q;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  // Independent of load so the FSM can reload on the same edge it expires.
  assign expire = tick && (count_q == TMR_W'(1));

endmodule

// File: rtl/alarm_controller.sv
// Alarm time register, daily match and ARMED/RINGING/SNOOZED buzzer FSM
// with snooze limit and auto-silence timed in whole minutes.
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              Clk,
  input  logic              Clr,
  alarm_controller_if.slave bus
);

  localparam logic [TMR_W-1:0] RING_LD    = TMR_W'(RING_MIN);
  localparam logic [TMR_W-1:0] SNOOZE_LD  = TMR_W'(SNOOZE_MIN);
  localparam logic [2:0]       SNOOZE_LIM = 3'(MAX_SNOOZE);

  alarm_state_e      state_q, state_d;
  logic [2:0]        snooze_cnt_q, snooze_cnt_d;
  logic [HOUR_W-1:0] alarm_hour_q;
  logic [MIN_W-1:0]  alarm_min_q;
  logic              buzzer_q;

  logic             set_valid;
  logic             match;
  logic             snooze_ok;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_load_val;
  logic             tmr_tick;
  logic             tmr_expire;

  assign set_valid = bus.AlarmSet && (bus.SetHour <= HOUR_MAX) && (bus.SetMin <= MIN_MAX);
  assign match     = bus.MinTick && (bus.Hour == alarm_hour_q) && (bus.Minute == alarm_min_q);
  assign snooze_ok = bus.Snooze && (snooze_cnt_q < SNOOZE_LIM);

  // The timer only counts a minute when nothing of higher priority claims the edge.
  assign tmr_tick = bus.Arm && !set_valid && !bus.Stop && bus.MinTick &&
                    ((state_q == RINGING && !snooze_ok) || state_q == SNOOZED);

  min_timer u_min_timer (
    .Clk      (Clk),
    .Clr      (Clr),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .tick     (tmr_tick),
    .expire   (tmr_expire)
  );

  always_comb begin
    state_d      = state_q;
    snooze_cnt_d = snooze_cnt_q;
    tmr_load     = 1'b0;
    tmr_load_val = RING_LD;
    if (!bus.Arm) begin
      state_d = IDLE;
    end else if (set_valid) begin
      state_d = ARMED;
      if (state_q == RINGING || state_q == SNOOZED) snooze_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d      = RINGING;
            tmr_load     = 1'b1;
            snooze_cnt_d = '0;
          end
        end
        RINGING: begin
          if (bus.Stop) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
          end else if (snooze_ok) begin
            state_d      = SNOOZED;
            tmr_load     = 1'b1;
            tmr_load_val = SNOOZE_LD;
            snooze_cnt_d = snooze_cnt_q + 3'd1;
          end else if (tmr_expire) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
          end
        end
        SNOOZED: begin
          if (bus.Stop) begin
            state_d      = ARMED;
            snooze_cnt_d = '0;
          end else if (tmr_expire) begin
            state_d  = RINGING;
            tmr_load = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state_q      <= IDLE;
      snooze_cnt_q <= '0;
      buzzer_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      snooze_cnt_q <= snooze_cnt_d;
      buzzer_q     <= (state_d == RINGING);
    end
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
    end else if (set_valid) begin
      alarm_hour_q <= bus.SetHour;
      alarm_min_q  <= bus.SetMin;
    end
  end

  assign bus.Buzzer    = buzzer_q;
  assign bus.AlarmHour = alarm_hour_q;
  assign bus.AlarmMin  = alarm_min_q;
  assign bus.State     = state_q;
  assign bus.SnoozeCnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table plus hand sequences for
// snooze limit, auto-silence, Arm drop and asynchronous reset mid-ring.
module tb_alarm_controller;

  typedef struct {
    logic       arm;
    logic       set;
    logic [4:0] sh;
    logic [5:0] sm;
    logic [4:0] hr;
    logic [5:0] mn;
    logic       tick;
    logic       snz;
    logic       stp;
    logic       e_buz;
    logic [1:0] e_st;
    logic [4:0] e_ah;
    logic [5:0] e_am;
    logic [2:0] e_cnt;
  } vec_t;

  logic Clk;
  logic Clr;
  int   n_cmp;
  int   n_err;
  vec_t tbl[$];

  alarm_controller_if bus ();

  alarm_controller #(.SNOOZE_MIN(5), .RING_MIN(10), .MAX_SNOOZE(3)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic vec_t mk(input logic arm, input logic set, input logic [4:0] sh,
                              input logic [5:0] sm, input logic [4:0] hr, input logic [5:0] mn,
                              input logic tick, input logic snz, input logic stp,
                              input logic e_buz, input logic [1:0] e_st, input logic [4:0] e_ah,
                              input logic [5:0] e_am, input logic [2:0] e_cnt);
    vec_t v;
    v.arm = arm; v.set = set; v.sh = sh; v.sm = sm; v.hr = hr; v.mn = mn;
    v.tick = tick; v.snz = snz; v.stp = stp;
    v.e_buz = e_buz; v.e_st = e_st; v.e_ah = e_ah; v.e_am = e_am; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, " Buzzer"},    int'(bus.Buzzer),    int'(v.e_buz));
    chk({tag, " State"},     int'(bus.State),     int'(v.e_st));
    chk({tag, " AlarmHour"}, int'(bus.AlarmHour), int'(v.e_ah));
    chk({tag, " AlarmMin"},  int'(bus.AlarmMin),  int'(v.e_am));
    chk({tag, " SnoozeCnt"}, int'(bus.SnoozeCnt), int'(v.e_cnt));
  endtask

  // driver: present one vector for exactly one rising edge, then check
  task automatic apply(input string tag, input vec_t v);
    @(negedge Clk);
    bus.Arm = v.arm; bus.AlarmSet = v.set; bus.SetHour = v.sh; bus.SetMin = v.sm;
    bus.Hour = v.hr; bus.Minute = v.mn; bus.MinTick = v.tick;
    bus.Snooze = v.snz; bus.Stop = v.stp;
    @(posedge Clk);
    #1;
    check_outs(tag, v);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    Clr = 1'b1;
    bus.Arm = 0; bus.AlarmSet = 0; bus.SetHour = 0; bus.SetMin = 0;
    bus.Hour = 0; bus.Minute = 0; bus.MinTick = 0; bus.Snooze = 0; bus.Stop = 0;
    repeat (2) @(posedge Clk);
    #1;
    check_outs("reset", mk(0,0,0,0,0,0,0,0,0, 0,2'd0,5'd0,6'd0,3'd0));
    @(negedge Clk);
    Clr = 1'b0;

    //           arm set sh  sm  hr mn  tk sz sp  buz st ah am cnt
    tbl.push_back(mk(0, 0, 0,  0,  0, 0,  0, 0, 0,  0, 0, 0, 0, 0));   // idle
    tbl.push_back(mk(1, 1, 7,  30, 7, 29, 0, 0, 0,  0, 1, 7, 30, 0));  // load 07:30, arm
    tbl.push_back(mk(1, 1, 24, 10, 7, 29, 0, 0, 0,  0, 1, 7, 30, 0));  // hour 24 rejected
    tbl.push_back(mk(1, 1, 5,  60, 7, 29, 0, 0, 0,  0, 1, 7, 30, 0));  // min 60 rejected
    tbl.push_back(mk(1, 0, 0,  0,  7, 29, 1, 0, 0,  0, 1, 7, 30, 0));  // no match
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 1, 0, 0,  1, 2, 7, 30, 0));  // match -> ring
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 0, 0, 0,  1, 2, 7, 30, 0));  // keeps ringing
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 0, 0, 1,  0, 1, 7, 30, 0));  // stop
    tbl.push_back(mk(1, 0, 0,  0,  7, 31, 1, 0, 0,  0, 1, 7, 30, 0));
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 1, 0, 0,  1, 2, 7, 30, 0));  // next day ring
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 0, 1, 1,  0, 1, 7, 30, 0));  // stop+snooze
    tbl.push_back(mk(0, 0, 0,  0,  7, 30, 1, 0, 0,  0, 0, 7, 30, 0));  // Arm=0 beats match
    tbl.push_back(mk(1, 0, 0,  0,  7, 30, 0, 0, 0,  0, 1, 7, 30, 0));
    tbl.push_back(mk(1, 1, 8,  15, 8, 15, 0, 0, 0,  0, 1, 8, 15, 0));  // set to current min
    tbl.push_back(mk(1, 0, 0,  0,  8, 16, 1, 0, 0,  0, 1, 8, 15, 0));
    tbl.push_back(mk(1, 0, 0,  0,  8, 15, 1, 0, 0,  1, 2, 8, 15, 0));  // next-day match
    tbl.push_back(mk(1, 0, 0,  0,  8, 15, 0, 1, 0,  0, 3, 8, 15, 1));  // snooze
    tbl.push_back(mk(1, 1, 9,  0,  8, 15, 0, 0, 0,  0, 1, 9, 0,  0));  // valid load in SNOOZED
    tbl.push_back(mk(0, 0, 0,  0,  8, 20, 0, 0, 0,  0, 0, 9, 0,  0));

    foreach (tbl[i]) apply($sformatf("v%0d", i), tbl[i]);

    // snooze limit: three re-rings after 5 ticks each, fourth snooze ignored
    apply("arm", mk(1,0,0,0, 9,10,0,0,0, 0,1,9,0,0));
    apply("ring", mk(1,0,0,0, 9,0,1,0,0, 1,2,9,0,0));
    for (int k = 1; k <= 3; k++) begin
      apply($sformatf("snz%0d", k), mk(1,0,0,0, 9,1,0,1,0, 0,3,9,0,3'(k)));
      for (int t = 1; t <= 4; t++)
        apply($sformatf("snz%0d t%0d", k, t), mk(1,0,0,0, 9,10,1,0,0, 0,3,9,0,3'(k)));
      apply($sformatf("rering%0d", k), mk(1,0,0,0, 9,10,1,0,0, 1,2,9,0,3'(k)));
    end
    apply("snz4 ignored", mk(1,0,0,0, 9,10,0,1,0, 1,2,9,0,3));

    // auto-silence after 10 ticks of unattended ringing
    for (int t = 1; t <= 9; t++)
      apply($sformatf("ring t%0d", t), mk(1,0,0,0, 9,20,1,0,0, 1,2,9,0,3));
    apply("auto silence", mk(1,0,0,0, 9,30,1,0,0, 0,1,9,0,0));

    // Arm drop keeps SnoozeCnt; the next match clears it
    apply("ring2", mk(1,0,0,0, 9,0,1,0,0, 1,2,9,0,0));
    apply("snz again", mk(1,0,0,0, 9,0,0,1,0, 0,3,9,0,1));
    apply("disarm", mk(0,0,0,0, 9,1,1,0,0, 0,0,9,0,1));
    apply("rearm", mk(1,0,0,0, 9,1,0,0,0, 0,1,9,0,1));
    apply("ring3", mk(1,0,0,0, 9,0,1,0,0, 1,2,9,0,0));

    // asynchronous reset mid-ring, then resume from IDLE
    #3;
    Clr = 1'b1;
    #1;
    check_outs("async clr", mk(0,0,0,0,0,0,0,0,0, 0,2'd0,5'd0,6'd0,3'd0));
    @(negedge Clk);
    Clr = 1'b0;
    apply("post clr", mk(1,0,0,0, 0,0,0,0,0, 0,1,0,0,0));
    apply("post clr tick", mk(1,0,0,0, 0,0,1,0,0, 1,2,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
